ex_div: RTL

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 20 ++
 rtl/ex_div_step.sv | 21 ++
 rtl/ex_div.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared opcode, width and helper definitions for the EX-stage divider.
// Opcode values mirror the core's common ALU operation defines.
package ex_div_pkg;

  localparam int ALU_OP_W = 8;
  localparam int REG_W    = 32;

  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  function automatic logic [REG_W-1:0] cond_neg(
    input logic [REG_W-1:0] v,
    input logic             n
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring shift-compare-subtract iteration of the divider.
// Combinational; the 33-bit compare keeps the partial remainder exact.
module div_step
  import ex_div_pkg::*;
(
  input  logic [REG_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [REG_W-1:0] divisor,
  output logic [REG_W-1:0] rem_out,
  output logic             q_bit
);

  logic [REG_W:0]   sh;
  logic [REG_W-1:0] sh_lo;

  assign sh      = {rem_in, bit_in};
  assign sh_lo   = {rem_in[REG_W-2:0], bit_in};
  assign q_bit   = sh >= {1'b0, divisor};
  assign rem_out = q_bit ? (sh_lo - divisor) : sh_lo;

endmodule

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU unit for the EX stage.
// Radix-2 restoring divider on magnitudes with sign fix-up at the end.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int ZERO_FAST = 1
)(
  input  logic                clock,
  input  logic                reset,
  input  logic [ALU_OP_W-1:0] ex_aluop,
  input  logic [REG_W-1:0]    ex_reg1,
  input  logic [REG_W-1:0]    ex_reg2,
  input  logic                annul,
  output logic                div_stall,
  output logic                div_ready,
  output logic [REG_W-1:0]    div_lo,
  output logic [REG_W-1:0]    div_hi
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ZERO,
    S_DONE
  } state_e;

  state_e           state;
  logic [5:0]       cnt;
  logic [REG_W-1:0] dvd;
  logic [REG_W-1:0] dvs;
  logic [REG_W-1:0] rem;
  logic [REG_W-1:0] res_lo;
  logic [REG_W-1:0] res_hi;
  logic             neg_q;
  logic             neg_r;

  logic             is_sdiv;
  logic             is_div;
  logic             start;
  logic [REG_W-1:0] step_rem;
  logic             step_q;
  logic [REG_W-1:0] q_fin;

  assign is_sdiv = ex_aluop == EXE_DIV_OP;
  assign is_div  = is_sdiv | (ex_aluop == EXE_DIVU_OP);
  assign start   = is_div & ~annul & (state == S_IDLE);

  // dvd shifts out dividend bits at the top and collects quotient bits below
  div_step u_step (
    .rem_in  (rem),
    .bit_in  (dvd[REG_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_fin = {dvd[REG_W-2:0], step_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dvd    <= ZERO_WORD;
      dvs    <= ZERO_WORD;
      rem    <= ZERO_WORD;
      res_lo <= ZERO_WORD;
      res_hi <= ZERO_WORD;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dvd   <= cond_neg(ex_reg1, is_sdiv & ex_reg1[REG_W-1]);
            dvs   <= cond_neg(ex_reg2, is_sdiv & ex_reg2[REG_W-1]);
            rem   <= ZERO_WORD;
            cnt   <= '0;
            neg_q <= is_sdiv & (ex_reg1[REG_W-1] ^ ex_reg2[REG_W-1]);
            neg_r <= is_sdiv & ex_reg1[REG_W-1];
            if (ex_reg2 == ZERO_WORD && ZERO_FAST == 1)
              state <= S_ZERO;
            else
              state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (annul) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            rem <= step_rem;
            dvd <= q_fin;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= S_DONE;
              cnt    <= '0;
              res_lo <= cond_neg(q_fin, neg_q);
              res_hi <= cond_neg(step_rem, neg_r);
            end
          end
        end
        S_ZERO: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            res_lo <= ZERO_WORD;
            res_hi <= ZERO_WORD;
            state  <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign div_stall = start | (state == S_BUSY) | (state == S_ZERO);
  assign div_ready = state == S_DONE;
  assign div_lo    = div_ready ? res_lo : ZERO_WORD;
  assign div_hi    = div_ready ? res_hi : ZERO_WORD;

endmodule
